dpb_port_arbiter: RTL
=====================

Name: dpb_port_arbiter

Overview:
- Shares channel A of the Gowin_DPB snake-map BSRAM (8-bit data, 11-bit address) between two requesters: req0 is the game/snake logic (read/write), req1 is the display scanner (read-only by convention, but writes are legal).
- Grants at most one access per clock and registers the winning command onto the DPB port.
- Routes each read result back to its issuer after the fixed BSRAM read latency.
- Sits between the snake update logic, the video scan logic and the DPB instance.

Parameters:
- AW, 11, address width (DPB ada).
- DW, 8, data width (DPB dina/douta).
- RD_LAT, 2, DPB read latency in clocks from the sampling edge to valid douta (2 = output-register/pipeline mode, 1 = bypass).
- PRIO_MODE, 0, 0 = round-robin between req0 and req1; 1 = fixed priority, req0 always wins.

Ports:
- clk  in  1  system clock, also drives DPB clka.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  AW  address.
- req0_wdata  in  DW  write data.
- rsp0_valid  out  1  read data valid for requester 0, one-cycle pulse.
- rsp0_rdata  out  DW  read data for requester 0.
- req1_valid / req1_ready / req1_we / req1_addr / req1_wdata / rsp1_valid / rsp1_rdata: same as above, for requester 1.
- dpb_cea  out  1  to DPB cea.
- dpb_ocea  out  1  to DPB ocea.
- dpb_wrea  out  1  to DPB wrea.
- dpb_ada  out  AW  to DPB ada.
- dpb_dina  out  DW  to DPB dina.
- dpb_douta  in  DW  from DPB douta.
- busy  out  1  at least one read in flight.

Behaviour:
- **Reset (async, rst_n=0):**
  - dpb_cea=0, dpb_ocea=0, dpb_wrea=0, dpb_ada=0, dpb_dina=0.
  - rsp*_valid=0, rsp*_rdata=0, busy=0.
  - Round-robin pointer selects req0 first; tag pipeline cleared.
- **After reset release:** dpb_cea and dpb_ocea are 1 constantly.
- **Handshake:**
  - reqN_ready is combinational: equals grantN.
  - A transfer happens in cycle H when reqN_valid && reqN_ready.
  - ready is never high while valid is low.
  - Requester holds valid, we, addr and wdata stable until ready.
- **Arbitration:**
  - Only one requester valid: it is granted.
  - Both valid, PRIO_MODE=0: grant the requester not granted most recently. The pointer updates only on an actual grant, so an idle cycle does not change it.
  - Both valid, PRIO_MODE=1: req0 wins; req1 may starve (intended).
- **Issue stage:**
  - On the edge ending cycle H, register the winner's addr to dpb_ada, wdata to dpb_dina, and we to dpb_wrea.
  - With no grant, dpb_wrea=0 and ada/dina hold their last value.
  - The DPB samples at the end of cycle H+1.
- **Read return:**
  - A shift register of depth RD_LAT+1 carries {valid, owner} for reads only.
  - rspN_valid=1 for exactly cycle H+1+RD_LAT (default H+3).
  - rspN_rdata is registered. It equals dpb_douta in that cycle, or is captured from it, so the value presents at H+1+RD_LAT.
  - rspN_rdata holds its last value otherwise.
- **Writes:** produce no response. Ordering is strictly issue order, so a read granted after a write to the same address returns the new data.
- **Throughput:** one access per clock sustained. Back-to-back reads from alternating owners return in the same order, each with its own owner.
- **busy:** 1 while any tag-pipeline stage holds a valid read.
- **Reset mid-operation:** in-flight reads are discarded (no rsp pulse after reset). A write registered but not yet sampled is cancelled (dpb_wrea forced 0).
- **Address:** passed through unmodified, full AW bits, no wrap logic.

Test Plan:
- **Reset:** hold rst_n=0 with req0_valid=1 -> req0_ready=0, dpb_wrea=0, dpb_cea=0, rsp*_valid=0.
- **Single path:** req0 write 0x5A at 0x123, then req0 read 0x123 -> one-cycle rsp0_valid exactly 3 clocks after the read handshake with rsp0_rdata=0x5A; rsp1_valid stays 0.
- **Round-robin, PRIO_MODE=0:** both valid with reads for 6 cycles -> grants alternate req0, req1, req0, ... starting with req0. Responses arrive in grant order, each 3 cycles after its handshake, with the correct owner and data.
- **Fixed priority, PRIO_MODE=1:** both valid continuously for 10 cycles -> req1_ready never asserts. Drop req0_valid -> req1 is granted in that same cycle.
- **Reset during flight:** read handshake at cycle H, rst_n low at H+1 -> no rsp pulse ever appears, busy=0 immediately.
- **Write-then-read ordering:** req1 write 0x00 at 0x7FF while req0 simultaneously reads 0x7FF, with req0 granted first -> req0 gets the old value. A subsequent req0 read gets 0x00.

Source files
------------

// File: rtl/dpb_port_arbiter_if.sv
// dpb_port_arbiter_if
//   Bundles the two requester handshakes and the DPB channel-A port used by
//   dpb_port_arbiter.
//   Ports (signals):
//     req0_* / req1_* : command valid/ready/we/addr/wdata per requester
//     rsp0_* / rsp1_* : read response pulse and data per requester
//     dpb_*           : BSRAM channel-A controls, address, data in/out
//   modport slave  : the arbiter side
//   modport master : the requester + BSRAM side
interface dpb_port_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          req0_valid;
  logic          req0_ready;
  logic          req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;

  logic          req1_valid;
  logic          req1_ready;
  logic          req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;

  logic          dpb_cea;
  logic          dpb_ocea;
  logic          dpb_wrea;
  logic [AW-1:0] dpb_ada;
  logic [DW-1:0] dpb_dina;
  logic [DW-1:0] dpb_douta;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  dpb_douta,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output dpb_cea, dpb_ocea, dpb_wrea, dpb_ada, dpb_dina
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output dpb_douta,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  dpb_cea, dpb_ocea, dpb_wrea, dpb_ada, dpb_dina
  );
endinterface

// File: rtl/dpb_port_arbiter.sv
// dpb_port_arbiter
//   Shares DPB channel A between requester 0 (snake logic) and requester 1
//   (display scanner). One grant per clock; the winning command is registered
//   onto the DPB port and each read result is routed back to its issuer
//   RD_LAT+1 cycles after the command is registered.
//   Ports:
//     clk   : system clock (also DPB clka)
//     rst_n : asynchronous active-low reset
//     bus   : requester handshakes + DPB port (slave modport)
//     busy  : at least one read in flight
module dpb_port_arbiter #(
  parameter int AW        = 11,
  parameter int DW        = 8,
  parameter int RD_LAT    = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpb_port_arbiter_if.slave    bus,
  output logic                 busy
);

  logic          en;
  logic          ptr;      // 1: req1 preferred on the next contested cycle
  logic          g0, g1;
  logic [RD_LAT:0] tag_v;
  logic [RD_LAT:0] tag_o;  // owner of each in-flight read, 1 = req1
  logic [DW-1:0] hold0, hold1;
  logic          rsp0, rsp1;

  // en keeps the port quiet (no grants, cea/ocea low) while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en <= 1'b0;
    else        en <= 1'b1;
  end

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (en) begin
      if (PRIO_MODE == 1) begin
        g0 = bus.req0_valid;
        g1 = bus.req1_valid & ~bus.req0_valid;
      end else begin
        g0 = bus.req0_valid & (~bus.req1_valid | ~ptr);
        g1 = bus.req1_valid & (~bus.req0_valid | ptr);
      end
    end
  end

  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;

  // Pointer only moves on an actual grant so idle cycles keep fairness state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= 1'b0;
    else if (g0) ptr <= 1'b1;
    else if (g1) ptr <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dpb_wrea <= 1'b0;
      bus.dpb_ada  <= '0;
      bus.dpb_dina <= '0;
    end else if (g0) begin
      bus.dpb_wrea <= bus.req0_we;
      bus.dpb_ada  <= bus.req0_addr;
      bus.dpb_dina <= bus.req0_wdata;
    end else if (g1) begin
      bus.dpb_wrea <= bus.req1_we;
      bus.dpb_ada  <= bus.req1_addr;
      bus.dpb_dina <= bus.req1_wdata;
    end else begin
      bus.dpb_wrea <= 1'b0;
    end
  end

  assign bus.dpb_cea  = en;
  assign bus.dpb_ocea = en;

  // Stage 0 is the cycle the command sits on the port; the last stage lines
  // up with valid douta and is the response cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v <= {tag_v[RD_LAT-1:0], (g0 & ~bus.req0_we) | (g1 & ~bus.req1_we)};
      tag_o <= {tag_o[RD_LAT-1:0], g1};
    end
  end

  assign busy = |tag_v;
  assign rsp0 = tag_v[RD_LAT] & ~tag_o[RD_LAT];
  assign rsp1 = tag_v[RD_LAT] &  tag_o[RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (rsp0) hold0 <= bus.dpb_douta;
      if (rsp1) hold1 <= bus.dpb_douta;
    end
  end

  // During the response cycle the data is taken straight from douta, then
  // held from the captured copy until the next response to that owner.
  assign bus.rsp0_valid = rsp0;
  assign bus.rsp1_valid = rsp1;
  assign bus.rsp0_rdata = rsp0 ? bus.dpb_douta : hold0;
  assign bus.rsp1_rdata = rsp1 ? bus.dpb_douta : hold1;

endmodule
